// File: rtl/clks_alot_rate_monitor_if.sv
// Edge, configuration and status bundle between the clock-recovery front-end and the rate monitor.
// The monitor connects through the slave modport; the edge source and rate consumer use the master modport.
interface clks_alot_rate_monitor_if #(
  parameter int COUNTER_WIDTH = 32
);
  logic                     rising_edge_i;
  logic                     falling_edge_i;
  logic                     even_50_50_en_i;
  logic                     lockin_enabled_i;
  logic                     pausable_en_i;
  logic [COUNTER_WIDTH-1:0] high_min_band_m1_i;
  logic [COUNTER_WIDTH-1:0] high_max_band_m1_i;
  logic [COUNTER_WIDTH-1:0] high_lockin_rate_i;
  logic [COUNTER_WIDTH-1:0] low_min_band_m1_i;
  logic [COUNTER_WIDTH-1:0] low_max_band_m1_i;
  logic [COUNTER_WIDTH-1:0] high_rate_o;
  logic [COUNTER_WIDTH-1:0] low_rate_o;
  logic                     rate_valid_o;
  logic                     over_frequency_violation_o;
  logic                     under_frequency_violation_o;
  logic                     edge_conflict_o;
  logic                     locked_o;
  logic                     pause_active_o;
  logic [COUNTER_WIDTH-1:0] pause_duration_o;

  modport slave (
    input  rising_edge_i, falling_edge_i, even_50_50_en_i, lockin_enabled_i, pausable_en_i,
    input  high_min_band_m1_i, high_max_band_m1_i, high_lockin_rate_i,
    input  low_min_band_m1_i, low_max_band_m1_i,
    output high_rate_o, low_rate_o, rate_valid_o, over_frequency_violation_o,
    output under_frequency_violation_o, edge_conflict_o, locked_o, pause_active_o, pause_duration_o
  );

  modport master (
    output rising_edge_i, falling_edge_i, even_50_50_en_i, lockin_enabled_i, pausable_en_i,
    output high_min_band_m1_i, high_max_band_m1_i, high_lockin_rate_i,
    output low_min_band_m1_i, low_max_band_m1_i,
    input  high_rate_o, low_rate_o, rate_valid_o, over_frequency_violation_o,
    input  under_frequency_violation_o, edge_conflict_o, locked_o, pause_active_o, pause_duration_o
  );
endinterface

// File: rtl/clks_alot_rate_monitor.sv
// Measures recovered-clock high/low half periods in sys_clk cycles, band-checks them, tracks lock and pause.
// All status is registered one cycle after the closing edge; edges are consumed every cycle, no backpressure.
module clks_alot_rate_monitor #(
  parameter int COUNTER_WIDTH = 32
) (
  input logic                     sys_clk,
  input logic                     sync_rst,
  clks_alot_rate_monitor_if.slave mon
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MEAS_HIGH = 2'd1;
  localparam logic [1:0] ST_MEAS_LOW  = 2'd2;
  localparam logic [1:0] ST_PAUSED    = 2'd3;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONES = '1;
  localparam logic [COUNTER_WIDTH:0]   EXT_ONE  = (COUNTER_WIDTH+1)'(1);

  logic [1:0]               state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
  logic [COUNTER_WIDTH-1:0] high_rate_q, high_rate_d;
  logic [COUNTER_WIDTH-1:0] low_rate_q, low_rate_d;
  logic [COUNTER_WIDTH-1:0] pause_dur_q, pause_dur_d;
  logic                     rate_valid_q, rate_valid_d;
  logic                     over_q, over_d;
  logic                     under_q, under_d;
  logic                     conflict_q, conflict_d;
  logic                     locked_q, locked_d;

  logic                     in_high, in_low, any_edge, both_edges, repeat_edge, closing;
  logic                     is_over, is_under, timeout, viol_ok, lock_reached;
  logic [COUNTER_WIDTH-1:0] act_min_m1, act_max_m1, meas_m1;
  logic [COUNTER_WIDTH-1:0] cnt_inc, lock_inc, pause_inc;
  logic [COUNTER_WIDTH:0]   lock_next_ext;

  always_comb begin
    in_high     = (state_q == ST_MEAS_HIGH);
    in_low      = (state_q == ST_MEAS_LOW);
    any_edge    = mon.rising_edge_i | mon.falling_edge_i;
    both_edges  = mon.rising_edge_i & mon.falling_edge_i;
    repeat_edge = (in_high & mon.rising_edge_i & ~mon.falling_edge_i) |
                  (in_low & mon.falling_edge_i & ~mon.rising_edge_i);
    closing     = (in_high & mon.falling_edge_i & ~mon.rising_edge_i) |
                  (in_low & mon.rising_edge_i & ~mon.falling_edge_i);
    // A symmetric clock checks its low phase against the high-phase band.
    act_min_m1  = (in_low && !mon.even_50_50_en_i) ? mon.low_min_band_m1_i : mon.high_min_band_m1_i;
    act_max_m1  = (in_low && !mon.even_50_50_en_i) ? mon.low_max_band_m1_i : mon.high_max_band_m1_i;
    meas_m1     = cnt_q - CNT_ONE;
    is_over     = (meas_m1 < act_min_m1);
    is_under    = (meas_m1 > act_max_m1);
    timeout     = (in_high | in_low) & ~any_edge & (meas_m1 > act_max_m1);
    viol_ok     = ~mon.lockin_enabled_i | locked_q;
    cnt_inc     = (cnt_q == CNT_ONES) ? cnt_q : cnt_q + CNT_ONE;
    lock_inc    = (lock_cnt_q == CNT_ONES) ? lock_cnt_q : lock_cnt_q + CNT_ONE;
    pause_inc   = (pause_dur_q == CNT_ONES) ? pause_dur_q : pause_dur_q + CNT_ONE;
    // Compared one bit wider so a saturated lock_cnt still reaches an all-ones rate.
    lock_next_ext = {1'b0, lock_cnt_q} + EXT_ONE;
    lock_reached  = (lock_next_ext >= {1'b0, mon.high_lockin_rate_i});
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = any_edge ? CNT_ONE : cnt_inc;
    lock_cnt_d   = lock_cnt_q;
    high_rate_d  = high_rate_q;
    low_rate_d   = low_rate_q;
    pause_dur_d  = (state_q == ST_PAUSED) ? pause_inc : pause_dur_q;
    rate_valid_d = 1'b0;
    over_d       = 1'b0;
    under_d      = 1'b0;
    conflict_d   = 1'b0;
    locked_d     = locked_q;

    if (both_edges || repeat_edge) begin
      conflict_d = 1'b1;
      locked_d   = 1'b0;
      lock_cnt_d = '0;
      if (both_edges) begin
        state_d = ST_IDLE;
      end
    end else if (closing) begin
      rate_valid_d = 1'b1;
      if (in_high) begin
        high_rate_d = cnt_q;
        state_d     = ST_MEAS_LOW;
      end else begin
        low_rate_d = cnt_q;
        state_d    = ST_MEAS_HIGH;
      end
      if (!is_over && !is_under) begin
        lock_cnt_d = lock_inc;
        if (!mon.lockin_enabled_i || lock_reached) begin
          locked_d = 1'b1;
        end
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
        over_d     = is_over & viol_ok;
        under_d    = is_under & viol_ok;
      end
    end else if (timeout) begin
      if (mon.pausable_en_i) begin
        state_d     = ST_PAUSED;
        pause_dur_d = CNT_ONE;
      end else begin
        under_d    = 1'b1;
        locked_d   = 1'b0;
        lock_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    end else if (any_edge) begin
      // Opening edge from IDLE, or resume from PAUSED; the elapsed segment is not a measurement.
      state_d = mon.rising_edge_i ? ST_MEAS_HIGH : ST_MEAS_LOW;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sync_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lock_cnt_q   <= '0;
      high_rate_q  <= '0;
      low_rate_q   <= '0;
      pause_dur_q  <= '0;
      rate_valid_q <= 1'b0;
      over_q       <= 1'b0;
      under_q      <= 1'b0;
      conflict_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      high_rate_q  <= high_rate_d;
      low_rate_q   <= low_rate_d;
      pause_dur_q  <= pause_dur_d;
      rate_valid_q <= rate_valid_d;
      over_q       <= over_d;
      under_q      <= under_d;
      conflict_q   <= conflict_d;
      locked_q     <= locked_d;
    end
  end

  assign mon.high_rate_o                 = high_rate_q;
  assign mon.low_rate_o                  = low_rate_q;
  assign mon.rate_valid_o                = rate_valid_q;
  assign mon.over_frequency_violation_o  = over_q;
  assign mon.under_frequency_violation_o = under_q;
  assign mon.edge_conflict_o             = conflict_q;
  assign mon.locked_o                    = locked_q;
  assign mon.pause_active_o              = (state_q == ST_PAUSED);
  assign mon.pause_duration_o            = pause_dur_q;

endmodule
